// File: rtl/task_a_pkg.sv
// task_a_pkg: shape index names and button FSM encoding shared across task A.
package task_a_pkg;
  localparam int SHAPE_BLANK          = 0;
  localparam int SHAPE_GREEN_CIRCLE   = 1;
  localparam int SHAPE_GREEN_SQUARE   = 2;
  localparam int SHAPE_GREEN_TRIANGLE = 3;
  localparam int SHAPE_RED_CIRCLE     = 4;
  localparam int SHAPE_RED_TRIANGLE   = 5;
  localparam int SHAPE_RED_SQUARE     = 6;
  localparam int SHAPE_BLANK_ORANGE   = 7;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_e;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running divider emitting a one-cycle enable every DIV clocks.
module tick_gen #(
  parameter int DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk)
    if (rst || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/btn_shape_sequencer.sv
// btn_shape_sequencer: debounces btnU, pulses once per accepted press and steps the shape index.
module btn_shape_sequencer
  import task_a_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int TICK_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 200,
  parameter int MAX_COUNT      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnU,
  output logic       press_pulse,
  output logic [2:0] count,
  output logic       doughnut_white,
  output logic       btn_level
);
  localparam int SW = $clog2(DEBOUNCE_TICKS + 1);
  logic [1:0] sync;
  logic btn_s, tick, accept;
  logic [SW-1:0] stab, stab_n;
  logic [2:0] next_count;
  btn_state_e state, state_n;
  assign btn_s = sync[1];
  assign btn_level = (state == HELD) || (state == RELEASE_WAIT);
  assign next_count = (count == 3'(MAX_COUNT)) ? 3'd0 : count + 3'd1;
  tick_gen #(.DIV(CLK_HZ / TICK_HZ)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  always_comb begin
    state_n = state;
    stab_n = stab;
    accept = 1'b0;
    unique case (state)
      IDLE: if (btn_s) begin
        state_n = PRESS_WAIT;
        stab_n = '0;
      end
      PRESS_WAIT: if (!btn_s) begin
        state_n = IDLE;
        stab_n = '0;
      end else if (tick) begin
        if (stab == SW'(DEBOUNCE_TICKS - 1)) begin
          state_n = HELD;
          accept = 1'b1;
        end else stab_n = stab + 1'b1;
      end
      HELD: if (!btn_s) begin
        state_n = RELEASE_WAIT;
        stab_n = '0;
      end
      RELEASE_WAIT: if (btn_s) begin
        state_n = HELD;
        stab_n = '0;
      end else if (tick) begin
        if (stab == SW'(DEBOUNCE_TICKS - 1)) state_n = IDLE;
        else stab_n = stab + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // count and colour advance together on the pulse cycle so they never disagree
  always_ff @(posedge clk)
    if (rst) begin
      sync <= '0;
      state <= IDLE;
      stab <= '0;
      press_pulse <= 1'b0;
      count <= '0;
      doughnut_white <= 1'b0;
    end else begin
      sync <= {sync[0], btnU};
      state <= state_n;
      stab <= stab_n;
      press_pulse <= accept;
      if (press_pulse) begin
        count <= next_count;
        doughnut_white <= next_count >= 3'(SHAPE_RED_CIRCLE) && next_count <= 3'(SHAPE_RED_SQUARE);
      end
    end
endmodule

// File: tb/tb_btn_shape_sequencer.sv
// tb_btn_shape_sequencer: directed and random press scenarios checked against a press-counting model.
module tb_btn_shape_sequencer;
  logic clk = 1'b0, rst = 1'b1, btnU = 1'b0;
  logic press_pulse, doughnut_white, btn_level;
  logic [2:0] count;
  int errors = 0, checks = 0;
  int pulses = 0, mcount = 0, base;
  logic prev_pulse = 1'b0, dbl = 1'b0;
  btn_shape_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_TICKS(4), .MAX_COUNT(7)) dut (
    .clk(clk), .rst(rst), .btnU(btnU), .press_pulse(press_pulse),
    .count(count), .doughnut_white(doughnut_white), .btn_level(btn_level));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (press_pulse) pulses <= pulses + 1;
    if (press_pulse && prev_pulse) dbl <= 1'b1;
    prev_pulse <= press_pulse;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic logic white_of(input int c);
    return c >= 4 && c <= 6;
  endfunction
  task automatic check_model(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(mcount));
    chk({tag, "_white"}, 32'(doughnut_white), 32'(white_of(mcount)));
  endtask
  task automatic press(input int hi, input int lo);
    btnU = 1'b1;
    cyc(hi);
    btnU = 1'b0;
    cyc(lo);
    mcount = (mcount + 1) % 8;
  endtask
  initial begin
    cyc(3);
    chk("rst_pulse", 32'(press_pulse), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_white", 32'(doughnut_white), 0);
    chk("rst_level", 32'(btn_level), 0);
    rst = 1'b0;
    cyc(20);
    base = pulses;
    press(100, 100);
    chk("clean_pulses", 32'(pulses - base), 1);
    check_model("clean");
    chk("clean_level", 32'(btn_level), 0);
    base = pulses;
    for (int i = 0; i < 12; i++) begin
      btnU = ~btnU;
      cyc(5);
    end
    btnU = 1'b0;
    cyc(100);
    chk("bounce_pulses", 32'(pulses - base), 0);
    check_model("bounce");
    chk("bounce_level", 32'(btn_level), 0);
    for (int i = 0; i < 8; i++) begin
      press(100, 100);
      check_model($sformatf("wrap%0d", i));
    end
    base = pulses;
    btnU = 1'b1;
    cyc(60);
    mcount = (mcount + 1) % 8;
    begin
      logic held_ok = 1'b1;
      for (int i = 0; i < 94; i++) begin
        cyc(10);
        if (btn_level !== 1'b1) held_ok = 1'b0;
      end
      chk("held_level", 32'(held_ok), 1);
    end
    chk("held_pulses", 32'(pulses - base), 1);
    btnU = 1'b0;
    cyc(15);
    btnU = 1'b1;
    cyc(100);
    chk("relbounce_pulses", 32'(pulses - base), 1);
    chk("relbounce_level", 32'(btn_level), 1);
    check_model("relbounce");
    btnU = 1'b0;
    cyc(100);
    chk("release_level", 32'(btn_level), 0);
    for (int i = 0; i < 8 && mcount != 5; i++) press(100, 100);
    check_model("pre_reset");
    base = pulses;
    btnU = 1'b1;
    cyc(20);
    rst = 1'b1;
    btnU = 1'b0;
    cyc(1);
    rst = 1'b0;
    mcount = 0;
    cyc(100);
    chk("midrst_pulses", 32'(pulses - base), 0);
    check_model("midrst");
    press(100, 100);
    check_model("post_rst");
    for (int i = 0; i < 20; i++) begin
      int kind = $urandom_range(0, 2);
      base = pulses;
      if (kind == 0) press($urandom_range(60, 150), $urandom_range(60, 150));
      else if (kind == 1) begin
        btnU = 1'b1;
        cyc($urandom_range(1, 25));
        btnU = 1'b0;
        cyc(60);
      end else begin
        btnU = 1'b1;
        cyc($urandom_range(60, 100));
        btnU = 1'b0;
        cyc($urandom_range(1, 25));
        press($urandom_range(30, 80), 80);
      end
      chk($sformatf("rnd%0d_pulses", i), 32'(pulses - base), kind == 1 ? 0 : 1);
      check_model($sformatf("rnd%0d", i));
      chk($sformatf("rnd%0d_level", i), 32'(btn_level), 0);
    end
    chk("pulse_width", 32'(dbl), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
